// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared constants for the register-file scan controller: register count,
// stall timeout and the FSM state encoding.
package regfile_scan_ctrl_pkg;

    localparam int         REG_COUNT     = 32;
    localparam logic [7:0] STALL_TIMEOUT = 8'd255;
    localparam logic [4:0] LAST_INDEX    = 5'd31;

    // State encoding kept as plain constants so legacy tools can read it.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_STALL   = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_RD_ADDR = 3'd3;
    localparam state_t ST_RD_WAIT = 3'd4;
    localparam state_t ST_OUT     = 3'd5;
    localparam state_t ST_WR      = 3'd6;
    localparam state_t ST_RELEASE = 3'd7;

    // Dump walks r0..r31; load skips r0 because r0 is hard-wired.
    function automatic logic [4:0] first_index(input logic load_mode);
        return load_mode ? 5'd1 : 5'd0;
    endfunction

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Register-file scan controller: freezes the processor, takes over the
// regfile test path, and either streams r0..r31 out or loads r1..r31 in.
module regfile_scan_ctrl
    import regfile_scan_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    output logic        proc_stall,
    input  logic        proc_idle,
    output logic        test,
    output logic        t_ctrl_writeEnable,
    output logic [4:0]  t_ctrl_writeReg,
    output logic [4:0]  t_ctrl_readRegA,
    output logic [4:0]  t_ctrl_readRegB,
    output logic [31:0] t_data_writeReg,
    input  logic [31:0] t_data_readRegA,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state;
    logic [4:0]  index;
    logic [7:0]  tcnt;
    logic        load_mode;
    logic        write_fire;

    // A write happens only in the cycle the load handshake completes in WR.
    always_comb begin
        write_fire = 1'b0;
        if ((state == ST_WR) && in_ready && in_valid) begin
            write_fire = 1'b1;
        end else begin
            write_fire = 1'b0;
        end
    end

    // Write-path outputs are gated so they read zero whenever no write fires.
    always_comb begin
        t_ctrl_writeEnable = 1'b0;
        t_ctrl_writeReg    = 5'd0;
        t_data_writeReg    = 32'd0;
        if (write_fire) begin
            t_ctrl_writeEnable = 1'b1;
            t_ctrl_writeReg    = index;
            t_data_writeReg    = in_data;
        end else begin
            t_ctrl_writeEnable = 1'b0;
            t_ctrl_writeReg    = 5'd0;
            t_data_writeReg    = 32'd0;
        end
    end

    assign t_ctrl_readRegB = 5'd0;

    // Main scan FSM with registered handshake, status and regfile-index outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            index           <= 5'd0;
            tcnt            <= 8'd0;
            load_mode       <= 1'b0;
            proc_stall      <= 1'b0;
            test            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= 32'd0;
            in_ready        <= 1'b0;
            t_ctrl_readRegA <= 5'd0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_STALL;
                        load_mode  <= mode;
                        index      <= first_index(mode);
                        tcnt       <= 8'd0;
                        proc_stall <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (proc_idle) begin
                        state <= ST_SETTLE;
                        test  <= 1'b1;
                    end else if (tcnt == STALL_TIMEOUT) begin
                        // Processor never froze: abort without touching the regfile.
                        state <= ST_RELEASE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    // One quiet cycle lets the port muxes switch before any access.
                    if (load_mode) begin
                        state    <= ST_WR;
                        in_ready <= 1'b1;
                    end else begin
                        state           <= ST_RD_ADDR;
                        t_ctrl_readRegA <= index;
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    out_data  <= t_data_readRegA;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (index == LAST_INDEX) begin
                            state <= ST_RELEASE;
                            done  <= 1'b1;
                        end else begin
                            index           <= index + 5'd1;
                            t_ctrl_readRegA <= index + 5'd1;
                            state           <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (in_valid) begin
                        if (index == LAST_INDEX) begin
                            state    <= ST_RELEASE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            index <= index + 5'd1;
                        end
                    end
                end
                ST_RELEASE: begin
                    state      <= ST_IDLE;
                    proc_stall <= 1'b0;
                    test       <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    proc_stall <= 1'b0;
                    test       <= 1'b0;
                    busy       <= 1'b0;
                    out_valid  <= 1'b0;
                    in_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Scoreboard bench for regfile_scan_ctrl: a behavioural regfile, a reference
// register image, randomized handshakes and a negedge monitor.
module tb_regfile_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start, mode, proc_stall, proc_idle, test;
    logic        t_ctrl_writeEnable;
    logic [4:0]  t_ctrl_writeReg, t_ctrl_readRegA, t_ctrl_readRegB;
    logic [31:0] t_data_writeReg, t_data_readRegA;
    logic        out_valid, out_ready, in_valid, in_ready, busy, done, error;
    logic [31:0] out_data, in_data;

    regfile_scan_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .proc_stall(proc_stall), .proc_idle(proc_idle), .test(test),
        .t_ctrl_writeEnable(t_ctrl_writeEnable), .t_ctrl_writeReg(t_ctrl_writeReg),
        .t_ctrl_readRegA(t_ctrl_readRegA), .t_ctrl_readRegB(t_ctrl_readRegB),
        .t_data_writeReg(t_data_writeReg), .t_data_readRegA(t_data_readRegA),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] rf_rdata;
    logic        pre_en;
    logic [31:0] ref_rf [32];

    logic [31:0] exp_words [$];
    logic [36:0] exp_writes [$];
    bit          exp_done_err [$];
    int          exp_done_lat [$];
    logic [31:0] load_q [$];
    int          xfer_log [$];
    int          wr_log [$];

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;
    chk_t chk_q [$];

    bit          hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic [12:0] outs_vec;

    assign outs_vec = {proc_stall, test, t_ctrl_writeEnable, |t_ctrl_writeReg,
                       |t_ctrl_readRegA, |t_ctrl_readRegB, |t_data_writeReg,
                       out_valid, |out_data, in_ready, busy, done, error};
    assign t_data_readRegA = rf_rdata;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural regfile: registered read, write on enable, bulk preload.
    always @(posedge clock) begin
        if (pre_en) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= i * 32'h11;
        end else if (t_ctrl_writeEnable) begin
            rf_mem[t_ctrl_writeReg] <= t_data_writeReg;
        end
        rf_rdata <= rf_mem[t_ctrl_readRegA];
    end

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: evaluates posted checks and pops the scoreboard on DUT outputs.
    always @(negedge clock) begin
        chk_t        c;
        logic [31:0] w;
        logic [36:0] e;
        bit          de;
        int          dl;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            total++;
            if (c.act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
            end
        end
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                total++;
                if ({out_valid, out_data} !== {1'b1, hold_data}) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, hold_data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                xfer_log.push_back(cyc);
                if (exp_words.size() == 0) begin
                    bad++;
                    $display("FAIL dump_word: got %h expected no word", out_data);
                end else begin
                    w = exp_words.pop_front();
                    if (out_data !== w) begin
                        bad++;
                        $display("FAIL dump_word: got %h expected %h", out_data, w);
                    end
                end
                hold_pending = 1'b0;
            end else if (out_valid) begin
                hold_pending = 1'b1;
                hold_data    = out_data;
            end else begin
                hold_pending = 1'b0;
            end
            if (t_ctrl_writeEnable) begin
                total++;
                wr_log.push_back(cyc);
                if (exp_writes.size() == 0) begin
                    bad++;
                    $display("FAIL write: got r%0d=%h expected no write", t_ctrl_writeReg, t_data_writeReg);
                end else begin
                    e = exp_writes.pop_front();
                    ref_rf[e[36:32]] = e[31:0];
                    if ({in_ready, t_ctrl_writeReg, t_data_writeReg} !== {1'b1, e}) begin
                        bad++;
                        $display("FAIL write: got r%0d=%h rdy=%b expected r%0d=%h rdy=1",
                                 t_ctrl_writeReg, t_data_writeReg, in_ready, e[36:32], e[31:0]);
                    end
                end
            end
            total++;
            if (error && !done) begin
                bad++;
                $display("FAIL error_alone: got error=1 done=0 expected error only with done");
            end
            if (done) begin
                done_cnt++;
                total++;
                if (exp_done_err.size() == 0) begin
                    bad++;
                    $display("FAIL done: got done=1 expected no done");
                end else begin
                    de = exp_done_err.pop_front();
                    dl = exp_done_lat.pop_front();
                    if (error !== de) begin
                        bad++;
                        $display("FAIL done_error: got %b expected %b", error, de);
                    end
                    if (dl != 0) begin
                        total++;
                        if (cyc - start_cyc != dl) begin
                            bad++;
                            $display("FAIL done_latency: got %0d expected %0d", cyc - start_cyc, dl);
                        end
                    end
                end
            end
        end
    end

    // One scan operation; caller is positioned just after a rising edge.
    task automatic run_op(input bit md, input int idle_delay, input bit rand_ready,
                          input bit rand_valid, input bit rand_data, input bit poke_start,
                          input int abort_after);
        int          n0_x, n0_w, d0, stall_cycles;
        bit          hs, saw_done, finished, test_seen;
        logic [31:0] d;
        n0_x = xfer_log.size();
        n0_w = wr_log.size();
        d0 = done_cnt;
        stall_cycles = 0;
        finished = 1'b0;
        test_seen = 1'b0;
        if (idle_delay < 0) begin
            exp_done_err.push_back(1'b1);
            exp_done_lat.push_back(256);
        end else begin
            if (!md) begin
                for (int i = 0; i < 32; i++) exp_words.push_back(ref_rf[i]);
            end else begin
                for (int k = 1; k < 32; k++) begin
                    d = rand_data ? $urandom : 32'hA000_0000 + k;
                    exp_writes.push_back({5'(k), d});
                    load_q.push_back(d);
                end
            end
            if (abort_after == 0) begin
                exp_done_err.push_back(1'b0);
                exp_done_lat.push_back(0);
            end
        end
        start = 1'b1;
        mode = md;
        out_ready = 1'b1;
        in_valid = (load_q.size() > 0);
        in_data = (load_q.size() > 0) ? load_q[0] : $urandom;
        @(posedge clock);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        post("start_accept", 32'(busy), 32'd1);
        for (int c = 0; c < 2000 && !finished; c++) begin
            @(negedge clock);
            hs = in_valid && in_ready;
            saw_done = done;
            if (test) test_seen = 1'b1;
            @(posedge clock);
            #1;
            if (hs) void'(load_q.pop_front());
            if (abort_after > 0 && (wr_log.size() - n0_w) >= abort_after) begin
                reset = 1'b1;
                #1;
                post("abort_outputs_zero", 32'(outs_vec), 32'd0);
                start = 1'b0;
                proc_idle = 1'b0;
                in_valid = 1'b0;
                load_q.delete();
                exp_writes.delete();
                repeat (3) @(posedge clock);
                #1;
                post("abort_writes", wr_log.size() - n0_w, 32'(abort_after));
                reset = 1'b0;
                finished = 1'b1;
            end else if (saw_done) begin
                post("after_done_test", 32'(test), 32'd0);
                post("after_done_stall", 32'(proc_stall), 32'd0);
                post("after_done_busy", 32'(busy), 32'd0);
                start = 1'b0;
                finished = 1'b1;
            end else begin
                if (proc_stall) stall_cycles++;
                proc_idle = proc_stall && (idle_delay >= 0) && (stall_cycles >= idle_delay);
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                in_valid = (load_q.size() > 0) && (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
                in_data = (load_q.size() > 0) ? load_q[0] : $urandom;
                mode = 1'($urandom_range(0, 1));
                start = poke_start && ((c % 17) == 5);
            end
        end
        proc_idle = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        post("op_finished", 32'(finished), 32'd1);
        post("done_count", done_cnt - d0, (abort_after > 0) ? 32'd0 : 32'd1);
        if (idle_delay < 0) begin
            post("timeout_writes", wr_log.size() - n0_w, 32'd0);
            post("timeout_test", 32'(test_seen), 32'd0);
        end else if (abort_after == 0 && !md) begin
            post("dump_words", xfer_log.size() - n0_x, 32'd32);
            if (!rand_ready && xfer_log.size() >= n0_x + 32)
                post("dump_span", xfer_log[n0_x + 31] - xfer_log[n0_x], 32'd93);
        end else if (abort_after == 0) begin
            post("load_writes", wr_log.size() - n0_w, 32'd31);
            if (!rand_valid && wr_log.size() >= n0_w + 31)
                post("load_span", wr_log[n0_w + 30] - wr_log[n0_w], 32'd30);
        end
    endtask

    // Stimulus sequence.
    initial begin
        start = 1'b0;
        mode = 1'b0;
        proc_idle = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_data = 32'd0;
        pre_en = 1'b1;
        for (int i = 0; i < 32; i++) ref_rf[i] = i * 32'h11;
        repeat (3) @(posedge clock);
        #1;
        post("reset_outputs", 32'(outs_vec), 32'd0);
        pre_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_op(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // dump of preloaded pattern
        run_op(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // load A000_0000+k
        run_op(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);   // readback
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 0);  // processor never idles
        run_op(1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 0);   // random ready, stray starts
        run_op(1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);   // random load, stray starts
        run_op(1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 10);  // reset after 10 writes
        run_op(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);   // restart after abort
        repeat (3) @(negedge clock);
        post("left_words", exp_words.size(), 32'd0);
        post("left_writes", exp_writes.size(), 32'd0);
        post("left_done", exp_done_err.size(), 32'd0);
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
